// File: rtl/pipe_sel_reg.sv
// pipe_sel_reg -- parametrised N:1 select feeding a PIPE_DEPTH-deep register
// chain with per-stage valid, stall and flush. Typical use is the write-back
// destination select (rt / rd / $31) registered into the next pipe stage.
//
// Optional feature macro: PIPE_SEL_BADSEL_EN (adds sticky sel_err output).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   in_data    NUM_IN packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   sel        binary channel select
//   in_valid   input qualifier (data is captured regardless)
//   stall      hold every stage
//   flush      clear every stage to RST_VAL/invalid; beats stall
//   out_data   last-stage data
//   out_valid  last-stage valid
//   sel_err    (PIPE_SEL_BADSEL_EN only) sticky: valid sample with bad select

// One pipeline register stage: clear beats enable.
module pipe_sel_stage #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             qv
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= RST_VAL;
      qv <= 1'b0;
    end else if (clr) begin
      q  <= RST_VAL;
      qv <= 1'b0;
    end else if (en) begin
      q  <= d;
      qv <= dv;
    end
  end
endmodule

module pipe_sel_reg #(
  parameter int               WIDTH      = 5,
  parameter int               NUM_IN     = 4,
  parameter int               SEL_W      = 2,
  parameter int               PIPE_DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid
`ifdef PIPE_SEL_BADSEL_EN
  ,
  output logic                    sel_err
`endif
);

  // Index 0 is the combinational select result; 1..PIPE_DEPTH are registers.
  logic [PIPE_DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [PIPE_DEPTH:0]            vld_pipe;
  logic [WIDTH-1:0]               mux;
  logic                           bad;

  // Codes NUM_IN..2**SEL_W-1 select nothing.
  assign bad = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

  always_comb begin
    mux = RST_VAL;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) mux = in_data[k*WIDTH +: WIDTH];
  end

  assign dat_pipe[0] = bad ? RST_VAL : mux;
  assign vld_pipe[0] = in_valid & ~bad;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    pipe_sel_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (~stall),
      .clr   (flush),
      .d     (dat_pipe[i]),
      .dv    (vld_pipe[i]),
      .q     (dat_pipe[i+1]),
      .qv    (vld_pipe[i+1])
    );
  end

  assign out_data  = dat_pipe[PIPE_DEPTH];
  assign out_valid = vld_pipe[PIPE_DEPTH];

`ifdef PIPE_SEL_BADSEL_EN
  // Sticky; only reset clears it, flush deliberately does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sel_err <= 1'b0;
    else if (!flush && !stall && in_valid && bad)
      sel_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_sel_reg.sv
module tb_pipe_sel_reg;

  typedef struct {
    int         cyc;
    logic [4:0] d;
    logic       v;
    string      nm;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0][4:0] ch;
  logic [19:0]     in_data;
  logic [1:0]      sel;
  logic            in_valid, stall, flush;
  logic [4:0]      d1, d2, d3;
  logic            v1, v2, v3;
  logic            err1, err2, err3;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q1[$], q2[$], q3[$], qe[$];

  assign in_data = ch;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u1: 4 inputs, depth 1
  pipe_sel_reg #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .PIPE_DEPTH(1), .RST_VAL(5'd0)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d1), .out_valid(v1)
`ifdef PIPE_SEL_BADSEL_EN
    , .sel_err(err1)
`endif
  );

  // u2: 3 inputs (sel=3 is bad), depth 2, nonzero reset value
  pipe_sel_reg #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .PIPE_DEPTH(2), .RST_VAL(5'd21)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data[14:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d2), .out_valid(v2)
`ifdef PIPE_SEL_BADSEL_EN
    , .sel_err(err2)
`endif
  );

  // u3: 4 inputs, depth 3
  pipe_sel_reg #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .PIPE_DEPTH(3), .RST_VAL(5'd0)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d3), .out_valid(v3)
`ifdef PIPE_SEL_BADSEL_EN
    , .sel_err(err3)
`endif
  );

`ifndef PIPE_SEL_BADSEL_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
  assign err3 = 1'b0;
`endif

  task automatic chk(input string nm, input int c, input logic [4:0] ad, input logic av,
                     input logic [4:0] ed, input logic ev);
    n_chk++;
    if (ad !== ed || av !== ev) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got data=%0d valid=%b expected data=%0d valid=%b",
               nm, c, ad, av, ed, ev);
    end
  endtask

  task automatic push(input int dut, input int c, input logic [4:0] d, input logic v,
                      input string nm);
    exp_t e;
    e = '{c, d, v, nm};
    case (dut)
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: qe.push_back(e);
    endcase
  endtask

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); chk(e.nm, cyc, d1, v1, e.d, e.v); end
    while (q2.size() > 0 && q2[0].cyc <= cyc) begin e = q2.pop_front(); chk(e.nm, cyc, d2, v2, e.d, e.v); end
    while (q3.size() > 0 && q3[0].cyc <= cyc) begin e = q3.pop_front(); chk(e.nm, cyc, d3, v3, e.d, e.v); end
`ifdef PIPE_SEL_BADSEL_EN
    while (qe.size() > 0 && qe[0].cyc <= cyc) begin e = qe.pop_front(); chk(e.nm, cyc, 5'd0, err2, 5'd0, e.v); end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sel      = 2'd0;
    ch[0]    = 5'd0;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    ch = '{5'd31, 5'd3, 5'd2, 5'd1};
    idle();

    // Reset state
    tick();
    push(1, cyc, 5'd0, 1'b0, "rst_u1");
    push(2, cyc, 5'd21, 1'b0, "rst_u2");
    push(3, cyc, 5'd0, 1'b0, "rst_u3");
    push(0, cyc, 5'd0, 1'b0, "rst_err");
    tick();
    reset = 1'b0;
    tick();

    // Bad select on u2 (NUM_IN=3, sel=3)
    n = cyc;
    sel = 2'd2; ch[2] = 5'd3; in_valid = 1'b1;
    push(2, n+2, 5'd3, 1'b1, "bad_pre");
    push(2, n+3, 5'd21, 1'b0, "bad_sel");
    push(2, n+4, 5'd0, 1'b0, "bad_post");
    push(0, n+1, 5'd0, 1'b0, "err_before");
    push(0, n+2, 5'd0, 1'b1, "err_set");
    tick();
    sel = 2'd3; in_valid = 1'b1;
    tick();
    idle();
    tick(); tick(); tick();

    // Flush beats stall on u2 (depth 2)
    n = cyc;
    sel = 2'd1; in_valid = 1'b1;
    push(2, n+2, 5'd2, 1'b1, "fl_full");
    push(2, n+3, 5'd21, 1'b0, "fl_flush");
    push(2, n+4, 5'd21, 1'b0, "fl_empty");
    push(2, n+5, 5'd6, 1'b1, "fl_refill");
    push(2, n+6, 5'd0, 1'b0, "fl_idle");
    push(0, n+3, 5'd0, 1'b1, "err_flush");
    push(0, n+6, 5'd0, 1'b1, "err_sticky");
    tick();
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0; sel = 2'd0; ch[0] = 5'd6; in_valid = 1'b1;
    tick();
    idle();
    tick(); tick(); tick();

    // Select sweep on u1 (depth 1)
    ch[0] = 5'd1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); in_valid = 1'b1;
      push(1, cyc+1, ch[i], 1'b1, $sformatf("sweep%0d", i));
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Latency and stall on u3 (depth 3)
    n = cyc;
    for (int i = 1; i <= 4; i++) push(3, n+i, 5'd0, 1'b0, $sformatf("st_hold%0d", i));
    push(3, n+5, 5'd7, 1'b1, "st_7");
    push(3, n+6, 5'd8, 1'b1, "st_8");
    push(3, n+7, 5'd9, 1'b1, "st_9");
    push(3, n+8, 5'd0, 1'b0, "st_end");
    sel = 2'd0; ch[0] = 5'd7; in_valid = 1'b1;
    tick();
    ch[0] = 5'd8;
    tick();
    stall = 1'b1; ch[0] = 5'd20;  // dropped: presented during stall
    tick();
    tick();
    stall = 1'b0; ch[0] = 5'd9;
    tick();
    idle();
    tick(); tick(); tick(); tick();

    // Valid passthrough on u1
    sel = 2'd1; ch[1] = 5'd12; in_valid = 1'b0;
    push(1, cyc+1, 5'd12, 1'b0, "vpass");
    tick();
    idle();
    ch[1] = 5'd2;
    tick();

    // Async reset mid-stream on u3
    n = cyc;
    sel = 2'd2; ch[2] = 5'd3; in_valid = 1'b1;
    push(3, n+3, 5'd3, 1'b1, "ar_pre");
    tick(); tick(); tick();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_now_u3", cyc, d3, v3, 5'd0, 1'b0);
    chk("ar_now_u2", cyc, d2, v2, 5'd21, 1'b0);
`ifdef PIPE_SEL_BADSEL_EN
    chk("ar_err_clr", cyc, 5'd0, err2, 5'd0, 1'b0);
`endif
    tick();
    n = cyc;
    reset = 1'b0;
    sel = 2'd1; in_valid = 1'b1;
    push(3, n+1, 5'd0, 1'b0, "ar_e1");
    push(3, n+2, 5'd0, 1'b0, "ar_e2");
    push(3, n+3, 5'd2, 1'b1, "ar_new");
    push(3, n+4, 5'd0, 1'b0, "ar_idle");
    tick();
    idle();
    tick(); tick(); tick(); tick(); tick();

    n = q1.size() + q2.size() + q3.size();
`ifdef PIPE_SEL_BADSEL_EN
    n += qe.size();
`endif
    n_chk++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL drain leftover=%0d expected=0", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sel_reg.md
Name: pipe_sel_reg

Overview:
Parametrised N-input select stage with a registered output pipeline, for the MIPS CPU datapath. It generalises the 2:1 register-address select to NUM_IN inputs of WIDTH bits, with a binary select and a PIPE_DEPTH-deep output register chain. Each stage carries a valid bit and responds to pipeline stall and flush. Typical use: write-back destination select between rt, rd and $31, registered into the next pipeline stage.

Parameters:
WIDTH, 5, bit width of each input channel and of out_data
NUM_IN, 4, number of input channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
PIPE_DEPTH, 1, number of register stages between select and output (1..4)
RST_VAL, 0, value loaded into data registers on reset, on flush and on a bad select

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  NUM_IN*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
sel  input  SEL_W  binary channel select
in_valid  input  1  input qualifier
stall  input  1  hold all stages
flush  input  1  invalidate all stages
out_data  output  WIDTH  last-stage data
out_valid  output  1  last-stage valid

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset=1, every stage has data=RST_VAL and valid=0, so out_data=RST_VAL and out_valid=0.
- Stage 0 next value, when neither flush nor stall is active:
  - sel < NUM_IN: data = channel[sel], valid = in_valid.
  - sel >= NUM_IN (bad select): data = RST_VAL, valid = 0.
- Stage i (1..PIPE_DEPTH-1) loads stage i-1 when neither flush nor stall is active.
- Outputs are driven directly from stage PIPE_DEPTH-1, with no combinational path from the inputs.
- Latency: a sample accepted at edge n appears on the outputs after edge n+PIPE_DEPTH-1, i.e. PIPE_DEPTH edges counting the capture edge.
- Data is captured regardless of in_valid; only the valid bit reflects in_valid.
- Stall (stall=1, flush=0): every stage holds data and valid. Input is not sampled, so a sample presented during a stall is dropped. The upstream stage must hold it.
- Flush (flush=1): every stage loads data=RST_VAL, valid=0 on the next edge. Flush overrides stall. The input on a flush cycle is discarded.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stream: immediate clear of all stages, without waiting for clk. On deassertion, stages refill normally; no sample from before the reset survives.
- Width rule: channel slices are exact WIDTH bits, with no extension or truncation. Unused select codes (NUM_IN to 2**SEL_W-1) are treated as bad select.
- With PIPE_DEPTH=1, this is a single registered mux with valid, stall and flush.

Optional Feature:
Macro PIPE_SEL_BADSEL_EN.
- Defined:
  - Adds output port sel_err (1 bit), a sticky flag.
  - sel_err is set on any edge where flush=0, stall=0, in_valid=1 and sel >= NUM_IN.
  - It is cleared only by reset (reset value 0); flush does not clear it.
  - It is registered, so it asserts one edge after the offending cycle.
- Not defined:
  - sel_err port and logic are absent.
  - Bad-select datapath behaviour (RST_VAL, valid=0) is unchanged.

Test Plan:
- Select sweep: WIDTH=5, NUM_IN=4, PIPE_DEPTH=1, channels 5'd1/5'd2/5'd3/5'd31, sel=0..3 with in_valid=1 on successive edges -> out_data 1,2,3,31 on successive edges, out_valid=1 throughout.
- Latency and stall: PIPE_DEPTH=3; push values 7,8,9 back to back; assert stall for 2 cycles after the second push -> outputs frozen during the stall; 7,8,9 emerge in order with no duplicates or loss; the total delay for 9 is 3 edges plus 2 stall edges.
- Flush priority: PIPE_DEPTH=2, pipeline full with valid data; assert stall=1 and flush=1 together -> next edge out_data=RST_VAL and out_valid=0. The output stays invalid until a new in_valid sample propagates 2 edges later.
- Bad select: NUM_IN=3, SEL_W=2, sel=3, in_valid=1 -> out_data=RST_VAL, out_valid=0.
  - With PIPE_SEL_BADSEL_EN: sel_err=1 one edge later; it stays 1 through a later flush and clears only on reset.
- Async reset mid-stream: assert reset between clock edges while out_valid=1 -> out_valid=0 and out_data=RST_VAL immediately, before the next edge. After release, the first new sample appears PIPE_DEPTH edges later.
- Valid passthrough: in_valid=0 with sel=1 and channel 1=5'd12 -> out_data=12 with out_valid=0 (data captured, not qualified).
